// File: rtl/mux_rr_arbiter_if.sv
// Requester/consumer bundle for the round-robin shared-datapath arbiter.
// The arbiter takes the slave side; producers and the consumer take the master side.
interface mux_rr_arbiter_if #(
  parameter int unsigned DATAWIDTH = 32
);
  logic [3:0]           req;
  logic [DATAWIDTH-1:0] din0;
  logic [DATAWIDTH-1:0] din1;
  logic [DATAWIDTH-1:0] din2;
  logic [DATAWIDTH-1:0] din3;
  logic [3:0]           gnt;
  logic [DATAWIDTH-1:0] dout;
  logic                 dout_valid;
  logic [1:0]           dout_src;
  logic                 dout_ready;

  modport master (
    output req, din0, din1, din2, din3, dout_ready,
    input  gnt, dout, dout_valid, dout_src
  );

  modport slave (
    input  req, din0, din1, din2, din3, dout_ready,
    output gnt, dout, dout_valid, dout_src
  );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Four-way round-robin arbiter sharing one registered datapath word.
// Grants are combinational; the granted word is held in dout until accepted.
module mux_rr_arbiter #(
  parameter int unsigned DATAWIDTH = 32
) (
  input  logic           Clk,
  input  logic           Rst,
  mux_rr_arbiter_if.slave bus
);

  localparam int unsigned NREQ = 4;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [1:0]           r_last_grant;
  logic [DATAWIDTH-1:0] r_dout;
  logic [1:0]           r_dout_src;
  logic                 r_dout_valid;

  logic                 w_accept;
  logic                 w_found;
  logic [1:0]           w_idx;
  logic [1:0]           w_win;
  logic [NREQ-1:0]      w_gnt;
  logic [DATAWIDTH-1:0] w_sel_din;

  // Next-state and grant: scan requesters starting just after the last winner
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_found     = 1'b0;
    w_idx       = 2'd0;
    w_win       = 2'd0;
    w_gnt       = '0;

    w_accept = !Rst && ((r_state == IDLE) || bus.dout_ready);

    for (int k = 1; k <= NREQ; k++) begin
      w_idx = r_last_grant + 2'(k);
      if (!w_found && bus.req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end

    if (w_accept) begin
      if (w_found) begin
        w_gnt       = NREQ'(1) << w_win;
        w_state_nxt = HOLD;
      end else begin
        w_state_nxt = IDLE;
      end
    end
  end

  always_comb begin
    w_sel_din = bus.din0;
    case (w_win)
      2'd0:    w_sel_din = bus.din0;
      2'd1:    w_sel_din = bus.din1;
      2'd2:    w_sel_din = bus.din2;
      default: w_sel_din = bus.din3;
    endcase
  end

  // State, last winner and output word; a reset discards any held word
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state      <= IDLE;
      r_last_grant <= 2'd3;
      r_dout       <= '0;
      r_dout_src   <= 2'd0;
      r_dout_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_dout_valid <= (w_state_nxt == HOLD);
      if (|w_gnt) begin
        r_dout       <= w_sel_din;
        r_dout_src   <= w_win;
        r_last_grant <= w_win;
      end
    end
  end

  assign bus.gnt        = w_gnt;
  assign bus.dout       = r_dout;
  assign bus.dout_src   = r_dout_src;
  assign bus.dout_valid = r_dout_valid;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: per-scenario tasks check grants inline,
// and a queue of expected captured words is checked after each capture edge.
module tb_mux_rr_arbiter;

  localparam int unsigned DW = 32;

  typedef struct {
    logic [DW-1:0] d;
    logic [1:0]    s;
  } exp_t;

  logic Clk;
  logic Rst;
  int   checks;
  int   errors;
  exp_t q[$];

  mux_rr_arbiter_if #(.DATAWIDTH(DW)) bus ();

  mux_rr_arbiter #(.DATAWIDTH(DW)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1);
  end

  // Scoreboard: words expected to be captured at this edge are checked just after it
  always @(posedge Clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (bus.dout_valid !== 1'b1 || bus.dout !== e.d || bus.dout_src !== e.s) begin
        errors++;
        $display("FAIL capture: got valid=%b dout=%h src=%0d, expected valid=1 dout=%h src=%0d",
                 bus.dout_valid, bus.dout, bus.dout_src, e.d, e.s);
      end
    end
  end

  task automatic drive(input logic [3:0] r, input logic rdy);
    bus.req        = r;
    bus.dout_ready = rdy;
  endtask

  task automatic push(input logic [DW-1:0] d, input logic [1:0] s);
    exp_t e;
    e.d = d;
    e.s = s;
    q.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    drive(4'b1111, 1'b1);
    @(negedge Clk);
    checks++;
    if (bus.gnt !== 4'b0000) begin
      errors++;
      $display("FAIL reset_gnt: got %b expected 0000", bus.gnt);
    end
    checks++;
    if (bus.dout !== '0 || bus.dout_valid !== 1'b0 || bus.dout_src !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: got dout=%h valid=%b src=%0d expected 0/0/0",
               bus.dout, bus.dout_valid, bus.dout_src);
    end
    next_cycle();
    drive(4'b0000, 1'b0);
    Rst = 1'b0;
  endtask

  task automatic test_single();
    bus.din0 = 32'h1111_1111;
    drive(4'b0001, 1'b1);
    @(negedge Clk);
    checks++;
    if (bus.gnt !== 4'b0001) begin
      errors++;
      $display("FAIL single_gnt: got %b expected 0001", bus.gnt);
    end
    push(32'h1111_1111, 2'd0);
    next_cycle();
    drive(4'b0000, 1'b1);
    @(negedge Clk);
    checks++;
    if (bus.gnt !== 4'b0000) begin
      errors++;
      $display("FAIL single_idle_gnt: got %b expected 0000", bus.gnt);
    end
    next_cycle();
    checks++;
    if (bus.dout_valid !== 1'b0 || bus.dout !== 32'h1111_1111) begin
      errors++;
      $display("FAIL single_idle: got valid=%b dout=%h expected valid=0 dout=11111111",
               bus.dout_valid, bus.dout);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [1:0] exp_s[5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [DW-1:0] vals[4] = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    Rst = 1'b1;
    next_cycle();
    Rst = 1'b0;
    bus.din0 = vals[0];
    bus.din1 = vals[1];
    bus.din2 = vals[2];
    bus.din3 = vals[3];
    drive(4'b1111, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      checks++;
      if (bus.gnt !== exp_g[i]) begin
        errors++;
        $display("FAIL rr_gnt[%0d]: got %b expected %b", i, bus.gnt, exp_g[i]);
      end
      push(vals[exp_s[i]], exp_s[i]);
      next_cycle();
    end
    drive(4'b0000, 1'b1);
    next_cycle();
    checks++;
    if (bus.dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL rr_idle: got valid=%b expected 0", bus.dout_valid);
    end
  endtask

  task automatic test_backpressure();
    bus.din2 = 32'hDEAD_BEEF;
    drive(4'b0100, 1'b1);
    @(negedge Clk);
    checks++;
    if (bus.gnt !== 4'b0100) begin
      errors++;
      $display("FAIL bp_first_gnt: got %b expected 0100", bus.gnt);
    end
    push(32'hDEAD_BEEF, 2'd2);
    next_cycle();
    bus.din0 = 32'h0000_00B0;
    bus.din1 = 32'h0000_00B1;
    bus.din3 = 32'h0000_00B3;
    drive(4'b1011, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      checks++;
      if (bus.gnt !== 4'b0000 || bus.dout !== 32'hDEAD_BEEF || bus.dout_valid !== 1'b1 ||
          bus.dout_src !== 2'd2) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got gnt=%b dout=%h valid=%b src=%0d expected 0000/deadbeef/1/2",
                 i, bus.gnt, bus.dout, bus.dout_valid, bus.dout_src);
      end
      next_cycle();
    end
    drive(4'b1011, 1'b1);
    @(negedge Clk);
    checks++;
    if (bus.gnt !== 4'b1000) begin
      errors++;
      $display("FAIL bp_release_gnt: got %b expected 1000", bus.gnt);
    end
    push(32'h0000_00B3, 2'd3);
    next_cycle();
    drive(4'b0000, 1'b1);
    next_cycle();
  endtask

  task automatic test_fairness();
    bus.din1 = 32'h0000_0C01;
    drive(4'b0010, 1'b1);
    @(negedge Clk);
    checks++;
    if (bus.gnt !== 4'b0010) begin
      errors++;
      $display("FAIL fair_setup_gnt: got %b expected 0010", bus.gnt);
    end
    push(32'h0000_0C01, 2'd1);
    next_cycle();
    drive(4'b0000, 1'b1);
    next_cycle();
    bus.din0 = 32'h0000_0C00;
    bus.din1 = 32'h0000_0C11;
    drive(4'b0011, 1'b1);
    @(negedge Clk);
    checks++;
    if (bus.gnt !== 4'b0001) begin
      errors++;
      $display("FAIL fair_wrap_gnt: got %b expected 0001", bus.gnt);
    end
    push(32'h0000_0C00, 2'd0);
    next_cycle();
    drive(4'b0010, 1'b1);
    @(negedge Clk);
    checks++;
    if (bus.gnt !== 4'b0010) begin
      errors++;
      $display("FAIL fair_next_gnt: got %b expected 0010", bus.gnt);
    end
    push(32'h0000_0C11, 2'd1);
    next_cycle();
    drive(4'b0000, 1'b1);
    next_cycle();
  endtask

  task automatic test_reset_mid();
    bus.din2 = 32'h1234_5678;
    drive(4'b0100, 1'b0);
    @(negedge Clk);
    checks++;
    if (bus.gnt !== 4'b0100) begin
      errors++;
      $display("FAIL rmid_setup_gnt: got %b expected 0100", bus.gnt);
    end
    push(32'h1234_5678, 2'd2);
    next_cycle();
    bus.din0 = 32'h0000_0D00;
    drive(4'b1111, 1'b0);
    Rst = 1'b1;
    @(negedge Clk);
    checks++;
    if (bus.gnt !== 4'b0000) begin
      errors++;
      $display("FAIL rmid_gnt: got %b expected 0000", bus.gnt);
    end
    next_cycle();
    checks++;
    if (bus.dout !== '0 || bus.dout_valid !== 1'b0 || bus.dout_src !== 2'd0) begin
      errors++;
      $display("FAIL rmid_state: got dout=%h valid=%b src=%0d expected 0/0/0",
               bus.dout, bus.dout_valid, bus.dout_src);
    end
    Rst = 1'b0;
    drive(4'b1111, 1'b1);
    @(negedge Clk);
    checks++;
    if (bus.gnt !== 4'b0001) begin
      errors++;
      $display("FAIL rmid_first_gnt: got %b expected 0001", bus.gnt);
    end
    push(32'h0000_0D00, 2'd0);
    next_cycle();
    drive(4'b0000, 1'b1);
    next_cycle();
  endtask

  task automatic test_withdraw();
    bus.din1 = 32'h0000_0E01;
    bus.din2 = 32'h0000_0E02;
    drive(4'b0010, 1'b0);
    @(negedge Clk);
    checks++;
    if (bus.gnt !== 4'b0010) begin
      errors++;
      $display("FAIL wd_setup_gnt: got %b expected 0010", bus.gnt);
    end
    push(32'h0000_0E01, 2'd1);
    next_cycle();
    drive(4'b0100, 1'b0);
    @(negedge Clk);
    checks++;
    if (bus.gnt !== 4'b0000) begin
      errors++;
      $display("FAIL wd_held_gnt: got %b expected 0000", bus.gnt);
    end
    next_cycle();
    drive(4'b0000, 1'b0);
    next_cycle();
    drive(4'b0000, 1'b1);
    @(negedge Clk);
    checks++;
    if (bus.gnt !== 4'b0000 || bus.dout_valid !== 1'b1) begin
      errors++;
      $display("FAIL wd_ready_gnt: got gnt=%b valid=%b expected 0000/1", bus.gnt, bus.dout_valid);
    end
    next_cycle();
    checks++;
    if (bus.dout_valid !== 1'b0 || bus.dout !== 32'h0000_0E01 || bus.dout_src !== 2'd1) begin
      errors++;
      $display("FAIL wd_idle: got valid=%b dout=%h src=%0d expected 0/00000e01/1",
               bus.dout_valid, bus.dout, bus.dout_src);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    Rst = 1'b1;
    bus.req = 4'b0000;
    bus.din0 = '0;
    bus.din1 = '0;
    bus.din2 = '0;
    bus.din3 = '0;
    bus.dout_ready = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_fairness();
    test_reset_mid();
    test_withdraw();
    repeat (2) next_cycle();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending words expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
